// File: rtl/md_seq_ctrl.sv
// Sequencing controller for the E-stage multiply/divide unit.
// Issues start pulses, runs the busy/latency counter, generates HI/LO write
// enables, stalls HI/LO-dependent D-stage instructions while an op is in
// flight, and suppresses issue on a pipeline flush.
//
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   e_md_valid   : E-stage instruction is an MD instruction
//   e_md_op[2:0] : 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo
//   flush        : kills the E-stage instruction this cycle
//   d_md_use     : D-stage instruction is an MD op, mfhi or mflo
//   md_start     : one-cycle start pulse to the MD datapath
//   md_op_o[2:0] : op presented to the MD datapath
//   md_busy      : MD operation in flight
//   stall        : freeze F/D, bubble into E
//   hi_we, lo_we : HI/LO write enables
//   op_err       : sticky, MD issue attempted while busy
module md_seq_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       e_md_valid,
  input  logic [2:0] e_md_op,
  input  logic       flush,
  input  logic       d_md_use,
  output logic       md_start,
  output logic [2:0] md_op_o,
  output logic       md_busy,
  output logic       stall,
  output logic       hi_we,
  output logic       lo_we,
  output logic       op_err
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       op_q, op_n;
  logic             err_q, err_n;
  logic             issue;

  // State and latched-operation registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= 3'b000;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      op_q  <= op_n;
      err_q <= err_n;
    end
  end

  // Next-state and output decode; reset forces every output low in its cycle
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    op_n     = op_q;
    err_n    = err_q;
    md_start = 1'b0;
    md_op_o  = op_q;
    md_busy  = 1'b0;
    hi_we    = 1'b0;
    lo_we    = 1'b0;
    issue    = e_md_valid & ~flush & (state == IDLE);

    unique case (state)
      IDLE: begin
        if (issue) begin
          unique case (e_md_op)
            OP_MULT, OP_MULTU: begin
              md_start = 1'b1;
              md_op_o  = e_md_op;
              op_n     = e_md_op;
              cnt_n    = MULT_LOAD;
              state_n  = RUN;
            end
            OP_DIV, OP_DIVU: begin
              md_start = 1'b1;
              md_op_o  = e_md_op;
              op_n     = e_md_op;
              cnt_n    = DIV_LOAD;
              state_n  = RUN;
            end
            OP_MTHI: begin
              hi_we   = 1'b1;
              md_op_o = e_md_op;
              op_n    = e_md_op;
            end
            OP_MTLO: begin
              lo_we   = 1'b1;
              md_op_o = e_md_op;
              op_n    = e_md_op;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        md_busy = 1'b1;
        // Upstream failed to honour stall; the new op is dropped
        if (e_md_valid) err_n = 1'b1;
        if (cnt == '0) begin
          hi_we   = 1'b1;
          lo_we   = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    if (reset) begin
      state_n  = IDLE;
      cnt_n    = '0;
      op_n     = 3'b000;
      err_n    = 1'b0;
      md_start = 1'b0;
      md_op_o  = 3'b000;
      md_busy  = 1'b0;
      hi_we    = 1'b0;
      lo_we    = 1'b0;
    end
  end

  assign stall  = d_md_use & (md_start | md_busy);
  assign op_err = err_q & ~reset;

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Self-checking bench for md_seq_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_md_seq_ctrl;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic       clk = 1'b0;
  logic       reset, e_md_valid, flush, d_md_use;
  logic [2:0] e_md_op;
  logic       md_start, md_busy, stall, hi_we, lo_we, op_err;
  logic [2:0] md_op_o;

  int checks = 0;
  int errors = 0;

  // Reference model: cycles of busy still to go, last presented op, sticky error
  int       m_left = 0;
  int       m_op   = 0;
  bit       m_err  = 1'b0;

  md_seq_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .e_md_valid(e_md_valid), .e_md_op(e_md_op),
    .flush(flush), .d_md_use(d_md_use), .md_start(md_start), .md_op_o(md_op_o),
    .md_busy(md_busy), .stall(stall), .hi_we(hi_we), .lo_we(lo_we),
    .op_err(op_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against model, advance model
  task automatic step(input bit rst, input bit v, input int op, input bit fl, input bit use_d);
    bit idle, iss, e_start, e_busy, e_hi, e_lo, e_stall, e_err;
    int e_op;
    @(negedge clk);
    reset = rst; e_md_valid = v; e_md_op = 3'(op); flush = fl; d_md_use = use_d;
    #1;
    idle    = (m_left == 0);
    iss     = v && !fl && idle;
    e_start = iss && op >= 1 && op <= 4;
    e_busy  = !idle;
    e_hi    = (m_left == 1) || (iss && op == 5);
    e_lo    = (m_left == 1) || (iss && op == 6);
    e_op    = (iss && op >= 1 && op <= 6) ? op : m_op;
    e_err   = m_err;
    if (rst) begin
      e_start = 0; e_busy = 0; e_hi = 0; e_lo = 0; e_op = 0; e_err = 0;
    end
    e_stall = use_d && (e_start || e_busy);
    chk("md_start", int'(md_start), int'(e_start));
    chk("md_busy",  int'(md_busy),  int'(e_busy));
    chk("hi_we",    int'(hi_we),    int'(e_hi));
    chk("lo_we",    int'(lo_we),    int'(e_lo));
    chk("md_op_o",  int'(md_op_o),  e_op);
    chk("stall",    int'(stall),    int'(e_stall));
    chk("op_err",   int'(op_err),   int'(e_err));
    if (rst) begin
      m_left = 0; m_op = 0; m_err = 0;
    end else begin
      if (!idle && v) m_err = 1;
      if (iss && op >= 1 && op <= 6) m_op = op;
      if (e_start) m_left = (op <= 2) ? MULT_N : DIV_N;
      else if (m_left > 0) m_left--;
    end
  endtask

  task automatic idle_n(input int n, input bit use_d);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, use_d);
  endtask

  int hi_seen;

  initial begin
    reset = 1; e_md_valid = 0; e_md_op = 0; flush = 0; d_md_use = 0;
    // mult started at cycle 2, busy 3..7, write enables at 7
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    idle_n(8, 0);
    // div with dependent mflo in D: stall over the whole flight
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 3, 0, 0);
    idle_n(12, 1);
    // divu flushed at issue, then reissued cleanly
    step(0, 1, 4, 1, 0);
    step(0, 1, 4, 0, 0);
    idle_n(12, 0);
    // mthi then mtlo back to back, D-stage use must not stall
    step(0, 1, 5, 0, 1);
    step(0, 1, 6, 0, 1);
    idle_n(2, 1);
    // ignored op codes
    step(0, 1, 0, 0, 1);
    step(0, 1, 7, 0, 1);
    // mult, then multu forced in while busy, then multu at T+N+1
    step(0, 1, 1, 0, 0);
    step(0, 1, 2, 0, 0);
    idle_n(MULT_N - 1, 0);
    step(0, 1, 2, 0, 0);
    idle_n(MULT_N + 1, 0);
    // flush during run has no effect
    step(0, 1, 3, 0, 0);
    for (int i = 0; i < int'(DIV_N); i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    // reset mid-div: no write enable may ever appear afterwards
    step(0, 1, 3, 0, 1);
    step(0, 1, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    hi_seen = 0;
    for (int i = 0; i < int'(DIV_N) + 2; i++) begin
      step(0, 0, 0, 0, 1);
      if (hi_we || lo_we) hi_seen++;
    end
    chk("no_we_after_reset", hi_seen, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 2) != 0),
           int'($urandom_range(0, 7)),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_seq_ctrl.md
Name: md_seq_ctrl

Overview:
Sequencing controller for the E-stage multiply/divide unit.
- Issues the start pulse and holds the latched operation code.
- Runs the multi-cycle latency counter and drives busy.
- Generates HI/LO write enables.
- Raises the D-stage stall for any HI/LO-dependent instruction while an operation is in flight.
- Suppresses issue when the pipeline is flushed by an exception or interrupt.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)
CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
e_md_valid  in  1  E-stage instruction is an MD instruction
e_md_op  in  3  op: 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo; others = none
flush  in  1  exception/interrupt flush this cycle; kills the E-stage instruction
d_md_use  in  1  D-stage instruction is an MD op, mfhi or mflo
md_start  out  1  one-cycle start pulse to the MD datapath
md_op_o  out  3  op presented to the MD datapath
md_busy  out  1  MD operation in flight
stall  out  1  freeze F/D, bubble into E
hi_we  out  1  HI write enable
lo_we  out  1  LO write enable
op_err  out  1  sticky: MD issue attempted while busy

Behaviour:
- Reset (sync, dominates every other input):
  - state=IDLE, cnt=0, md_op_o=000, op_err=0.
  - All other outputs are 0 during and after the reset cycle.
- issue = e_md_valid & ~flush & (state==IDLE).
- States: IDLE, RUN.
- IDLE, issue with op in 001..100:
  - md_start=1, combinational, same cycle.
  - md_op_o is driven combinationally from e_md_op and latched at the edge.
  - cnt <= MULT_CYCLES-1 for 001/010, DIV_CYCLES-1 for 011/100.
  - Next state RUN.
- RUN:
  - md_busy=1, md_op_o holds the latched op.
  - cnt decrements each cycle.
  - In the cycle cnt==0: hi_we=1, lo_we=1; next state IDLE.
  - Result: start in cycle T; busy in cycles T+1..T+N; write enables in cycle T+N; IDLE at T+N+1.
- IDLE, issue with op 101 (mthi): hi_we=1 same cycle, md_op_o=101, no busy, state stays IDLE.
- IDLE, issue with op 110 (mtlo): lo_we=1 same cycle, md_op_o=110, no busy, state stays IDLE.
- Op 000 or 111 with e_md_valid: ignored, no outputs.
- flush=1 in an IDLE issue cycle: md_start, hi_we and lo_we all 0; state unchanged.
- flush during RUN: no effect; the in-flight op is older than the faulting instruction and completes.
- stall = d_md_use & (md_start | md_busy).
  - Stall drops in cycle T+N+1, so a dependent mfhi/mflo reaches E after the HI/LO write.
- e_md_valid=1 while in RUN (stall not honoured upstream):
  - op_err <= 1 (sticky until reset).
  - The op is ignored; the running op continues.
- Back-to-back: a new start is accepted in the first IDLE cycle after completion (T+N+1). Minimum issue spacing is N+1 cycles.
- Divide by zero: same latency; no special handling.
- Reset in RUN: operation abandoned; no write enables are issued.

Test Plan:
- mult, MULT_CYCLES=5, start at cycle 2:
  - md_start=1 in cycle 2 only.
  - md_busy=1 in cycles 3..7.
  - hi_we=lo_we=1 in cycle 7 only.
  - md_op_o=001 throughout.
- div issued, then d_md_use=1 (mflo) from cycle 3:
  - stall=1 in cycles 3..12.
  - stall=0 at cycle 13.
  - hi_we/lo_we=1 at cycle 12 (DIV_CYCLES=10, start at 2).
- divu with flush=1 in the issue cycle:
  - md_start=0, md_busy stays 0, no write enables.
  - The same op reissued without flush one cycle later starts normally.
- mthi then mtlo in consecutive IDLE cycles:
  - hi_we=1 in cycle 1, lo_we=1 in cycle 2.
  - md_busy and stall remain 0 even with d_md_use=1.
- mult, then multu forced in while busy:
  - op_err=1 from the next cycle.
  - The running mult completes at its original cycle.
  - A multu issued at cycle T+N+1 starts.
- reset asserted at cycle 4 of a running div:
  - Next cycle: md_busy=0, stall=0, md_op_o=000.
  - No hi_we/lo_we pulse ever appears.
  - op_err cleared.
